// File: rtl/msg_request_queue.sv
// Request queue between the session manager and the create message engine.
// Buffers typed requests in a FIFO and hands them to the engine one at a time.
`ifndef VALUE_DATA_WIDTH
`define VALUE_DATA_WIDTH 32
`endif
`ifndef VALUE_SIZE
`define VALUE_SIZE 8
`endif

module msg_request_queue #(
   parameter int VALUE_WIDTH  = `VALUE_DATA_WIDTH,
   parameter int SIZE         = `VALUE_SIZE,
   parameter int DEPTH        = 4,
   parameter int DONE_TIMEOUT = 255
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       initiate_msg_i,
   input  logic [3:0]                 create_message_i,
   input  logic [VALUE_WIDTH-1:0]     targetCompId_i,
   input  logic [SIZE-1:0]            s_v_targetCompId_i,
   input  logic                       busy_i,
   input  logic                       done_i,
   output logic                       start_o,
   output logic [3:0]                 msg_type_o,
   output logic [VALUE_WIDTH-1:0]     targetCompId_o,
   output logic [SIZE-1:0]            s_v_targetCompId_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       overflow_o,
   output logic [7:0]                 drop_cnt_o,
   output logic                       timeout_err_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(DONE_TIMEOUT + 1);
   localparam int EW = 4 + VALUE_WIDTH + SIZE;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(32'd1);
   localparam logic [TW-1:0] TMO_ONE  = TW'(32'd1);
   localparam logic [TW-1:0] TMO_LAST = TW'(DONE_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t          state_r, state_s;
   logic [EW-1:0]   mem_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
   logic [CW-1:0]   count_r, count_s;
   logic [TW-1:0]   tmo_cnt_r;
   logic            push_req_s, push_s, pop_s, drop_s, timeout_s;
   logic            start_r, full_r, empty_r, overflow_r, timeout_r;
   logic [3:0]      msg_type_r;
   logic [VALUE_WIDTH-1:0] comp_id_r;
   logic [SIZE-1:0] comp_sz_r;
   logic [7:0]      drop_cnt_r;

   // FSM next-state, pop/push qualification and next occupancy
   always_comb begin
      state_s   = state_r;
      pop_s     = 1'b0;
      timeout_s = 1'b0;
      case (state_r)
         IDLE: begin
            if ((count_r != {CW{1'b0}}) && !busy_i) begin
               pop_s   = 1'b1;
               state_s = WAIT_BUSY;
            end else begin
               state_s = IDLE;
            end
         end
         WAIT_BUSY, WAIT_DONE: begin
            // a completion in the final cycle wins over the timeout
            if (done_i) begin
               state_s = IDLE;
            end else if (tmo_cnt_r == TMO_LAST) begin
               timeout_s = 1'b1;
               state_s   = IDLE;
            end else if (busy_i) begin
               state_s = WAIT_DONE;
            end else begin
               state_s = state_r;
            end
         end
         default: state_s = IDLE;
      endcase
      push_req_s = initiate_msg_i && (create_message_i != 4'b0000);
      push_s     = push_req_s && ((count_r != DEPTH_C) || pop_s);
      drop_s     = push_req_s && (count_r == DEPTH_C) && !pop_s;
      if (push_s && !pop_s) begin
         count_s = count_r + CNT_ONE;
      end else if (pop_s && !push_s) begin
         count_s = count_r - CNT_ONE;
      end else begin
         count_s = count_r;
      end
   end

   // FIFO storage; an entry is always written before it can be read
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {create_message_i, targetCompId_i, s_v_targetCompId_i};
      end
   end

   // Control, status and payload registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         count_r    <= {CW{1'b0}};
         full_r     <= 1'b0;
         empty_r    <= 1'b1;
         tmo_cnt_r  <= {TW{1'b0}};
         start_r    <= 1'b0;
         timeout_r  <= 1'b0;
         overflow_r <= 1'b0;
         drop_cnt_r <= 8'd0;
         msg_type_r <= 4'd0;
         comp_id_r  <= {VALUE_WIDTH{1'b0}};
         comp_sz_r  <= {SIZE{1'b0}};
      end else begin
         state_r   <= state_s;
         count_r   <= count_s;
         full_r    <= (count_s == DEPTH_C);
         empty_r   <= (count_s == {CW{1'b0}});
         start_r   <= pop_s;
         timeout_r <= timeout_s;
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
            {msg_type_r, comp_id_r, comp_sz_r} <= mem_r[rd_ptr_r];
         end
         // the timeout window restarts with every issued request
         if (pop_s || (state_r == IDLE)) begin
            tmo_cnt_r <= {TW{1'b0}};
         end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
         end
         if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_cnt_r != 8'hFF) begin
               drop_cnt_r <= drop_cnt_r + 8'd1;
            end
         end
      end
   end

   assign start_o            = start_r;
   assign msg_type_o         = msg_type_r;
   assign targetCompId_o     = comp_id_r;
   assign s_v_targetCompId_o = comp_sz_r;
   assign full_o             = full_r;
   assign empty_o            = empty_r;
   assign count_o            = count_r;
   assign overflow_o         = overflow_r;
   assign drop_cnt_o         = drop_cnt_r;
   assign timeout_err_o      = timeout_r;

endmodule

// File: tb/tb_msg_request_queue.sv
// Directed bench for msg_request_queue: expected start payloads go into a
// scoreboard queue, a negedge monitor pops and compares on every start_o.
module tb_msg_request_queue;

   localparam int VW = 16;
   localparam int SZ = 8;
   localparam logic [3:0] LOGON     = 4'd1;
   localparam logic [3:0] LOGOUT    = 4'd2;
   localparam logic [3:0] HEARTBEAT = 4'd3;
   localparam logic [3:0] RESEND    = 4'd4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          initiate_msg_i;
   logic [3:0]    create_message_i;
   logic [VW-1:0] targetCompId_i;
   logic [SZ-1:0] s_v_targetCompId_i;
   logic          busy_i, done_i;
   logic          start_o;
   logic [3:0]    msg_type_o;
   logic [VW-1:0] targetCompId_o;
   logic [SZ-1:0] s_v_targetCompId_o;
   logic          full_o, empty_o;
   logic [2:0]    count_o;
   logic          overflow_o;
   logic [7:0]    drop_cnt_o;
   logic          timeout_err_o;

   int checks = 0;
   int failures = 0;
   logic [27:0] exp_q[$];
   logic [27:0] exp_e;

   msg_request_queue #(.VALUE_WIDTH(VW), .SIZE(SZ), .DEPTH(4), .DONE_TIMEOUT(255)) dut (
      .clk(clk), .rst_n(rst_n),
      .initiate_msg_i(initiate_msg_i), .create_message_i(create_message_i),
      .targetCompId_i(targetCompId_i), .s_v_targetCompId_i(s_v_targetCompId_i),
      .busy_i(busy_i), .done_i(done_i),
      .start_o(start_o), .msg_type_o(msg_type_o),
      .targetCompId_o(targetCompId_o), .s_v_targetCompId_o(s_v_targetCompId_o),
      .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
      .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o), .timeout_err_o(timeout_err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] t, input logic [15:0] id, input logic [7:0] sz,
                       input bit accept);
      initiate_msg_i = 1'b1;
      create_message_i = t;
      targetCompId_i = id;
      s_v_targetCompId_i = sz;
      if (accept) exp_q.push_back({t, id, sz});
      tick();
      initiate_msg_i = 1'b0;
      create_message_i = 4'd0;
   endtask

   // Wait for each start, then emulate the engine: busy for busy_cycles, then done.
   task automatic serve(input int n, input int busy_cycles, input int exp_wait);
      int waited;
      for (int k = 0; k < n; k++) begin
         waited = 0;
         while (start_o !== 1'b1 && waited < 20) begin
            tick();
            waited++;
         end
         chk("start_seen", start_o, 1);
         if (exp_wait >= 0 && k > 0) chk("b2b_gap", waited, exp_wait);
         for (int b = 0; b < busy_cycles; b++) begin
            busy_i = 1'b1;
            tick();
         end
         busy_i = 1'b0;
         done_i = 1'b1;
         tick();
         done_i = 1'b0;
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_start", start_o, 0);
      chk("rst_payload", {msg_type_o, targetCompId_o, s_v_targetCompId_o}, 0);
      chk("rst_full", full_o, 0);
      chk("rst_empty", empty_o, 1);
      chk("rst_count", count_o, 0);
      chk("rst_overflow", overflow_o, 0);
      chk("rst_drop_cnt", drop_cnt_o, 0);
      chk("rst_timeout", timeout_err_o, 0);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && start_o) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_start", start_o, 0);
         end else begin
            exp_e = exp_q.pop_front();
            chk("start_payload", {4'd0, msg_type_o, targetCompId_o, s_v_targetCompId_o},
                {4'd0, exp_e});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      int t;
      rst_n = 1'b0;
      initiate_msg_i = 1'b0;
      create_message_i = 4'd0;
      targetCompId_i = '0;
      s_v_targetCompId_i = '0;
      busy_i = 1'b0;
      done_i = 1'b0;
      repeat (2) tick();
      chk_reset_outputs();
      @(negedge clk) rst_n = 1'b1;
      tick();

      // single logon, one-cycle issue latency, busy 3 then done
      push(LOGON, 16'h0041, 8'h02, 1'b1);
      chk("logon_count", count_o, 1);
      chk("logon_empty", empty_o, 0);
      tick();
      chk("logon_latency", start_o, 1);
      chk("logon_type", msg_type_o, LOGON);
      chk("logon_compid", targetCompId_o, 16'h0041);
      chk("logon_popped", empty_o, 1);
      serve(1, 3, -1);
      repeat (2) tick();
      chk("logon_idle_empty", empty_o, 1);

      // zero type code is ignored
      push(4'd0, 16'h0099, 8'h01, 1'b0);
      chk("zero_type_count", count_o, 0);
      chk("zero_type_drop", drop_cnt_o, 0);

      // engine busy: fill, overflow one
      busy_i = 1'b1;
      push(LOGON,     16'h1111, 8'h11, 1'b1);
      push(LOGOUT,    16'h2222, 8'h22, 1'b1);
      push(HEARTBEAT, 16'h3333, 8'h33, 1'b1);
      chk("fill3_full", full_o, 0);
      push(RESEND,    16'h4444, 8'h44, 1'b1);
      chk("fill4_full", full_o, 1);
      chk("fill4_count", count_o, 4);
      push(LOGON,     16'h5555, 8'h55, 1'b0);
      chk("drop_overflow", overflow_o, 1);
      chk("drop_cnt", drop_cnt_o, 1);
      chk("drop_count", count_o, 4);
      // release busy with a push on the same edge as the pop
      busy_i = 1'b0;
      push(LOGOUT, 16'h6666, 8'h66, 1'b1);
      chk("pushpop_start", start_o, 1);
      chk("pushpop_count", count_o, 4);
      chk("pushpop_full", full_o, 1);
      chk("pushpop_drop", drop_cnt_o, 1);
      serve(5, 1, 1);
      tick();
      chk("drain_empty", empty_o, 1);
      chk("overflow_sticky", overflow_o, 1);

      // engine never responds: timeout, then next request issues
      push(HEARTBEAT, 16'hAAAA, 8'h0A, 1'b1);
      push(RESEND,    16'hBBBB, 8'h0B, 1'b1);
      chk("tmo_start", start_o, 1);
      t = 0;
      while (timeout_err_o !== 1'b1 && t < 300) begin
         tick();
         t++;
      end
      chk("timeout_latency", t, 255);
      tick();
      chk("timeout_pulse_end", timeout_err_o, 0);
      chk("after_timeout_start", start_o, 1);
      serve(1, 0, -1);

      // reset while in WAIT_DONE with two entries queued
      push(LOGON, 16'hC0C0, 8'h0C, 1'b1);
      push(LOGOUT, 16'hD0D0, 8'h0D, 1'b1);
      busy_i = 1'b1;
      push(HEARTBEAT, 16'hE0E0, 8'h0E, 1'b1);
      chk("mid_count", count_o, 2);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk_reset_outputs();
      busy_i = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      repeat (10) tick();
      chk("post_rst_count", count_o, 0);
      chk("post_rst_nostart", start_o, 0);
      push(RESEND, 16'hF0F0, 8'h0F, 1'b1);
      serve(1, 1, -1);
      tick();
      chk("sb_leftover", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
